// File: rtl/my_nios1_switch_pkg.sv
// Shared definitions for the slide-switch debounce controller: register map,
// CTRL layout, edge-mode encodings and counter width helpers.
package my_nios1_switch_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CTRL_W      = 3;
  localparam int CTRL_BYPASS = 2;
  localparam logic [CTRL_W-1:0] CTRL_RESET = 3'b011;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic int presc_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  function automatic int cnt_width(input int ticks);
    return (ticks > 2) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/my_nios1_debounce_bit.sv
// One switch input: 2-FF synchroniser, tick-based debounce counter and the
// accepted (stable) level. 'change' flags a real accepted transition this clk.
module my_nios1_debounce_bit
  import my_nios1_switch_pkg::*;
#(
  parameter int DB_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic tick,
  input  logic bypass,
  input  logic init,
  output logic stable,
  output logic change
);

  localparam int CW = cnt_width(DB_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          accept;

  // The init load happens on a tick just like a normal acceptance, but never reports a change.
  assign accept = bypass || (tick && (init || (cnt == CNT_LAST)));
  assign change = accept && !init && (sync != stable);

  // NOTE: non-blocking assignments let meta->sync shift in one edge; blocking would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else if (init || (sync == stable)) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/my_nios1_switch_debounce_ctrl.sv
// Avalon-MM slide-switch controller: debounced levels, edge capture with W1C,
// per-bit interrupt mask and a registered level interrupt.
module my_nios1_switch_debounce_ctrl
  import my_nios1_switch_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000,
  parameter int DB_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]     presc;
  logic              tick;
  logic              init;
  logic [WIDTH-1:0]  stable;
  logic [WIDTH-1:0]  change;
  logic [WIDTH-1:0]  mask;
  logic [WIDTH-1:0]  edges;
  logic [WIDTH-1:0]  edge_set;
  logic [WIDTH-1:0]  w1c;
  logic [CTRL_W-1:0] ctrl;
  logic              bypass;
  logic              rise_en;
  logic              fall_en;
  logic [31:0]       rd_next;
  edge_mode_e        mode;

  assign tick   = (presc == PRESC_LAST);
  assign bypass = ctrl[CTRL_BYPASS];
  assign mode   = edge_mode_e'(ctrl[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      init  <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick || bypass) init <= 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    my_nios1_debounce_bit #(
      .DB_TICKS(DB_TICKS)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .tick  (tick),
      .bypass(bypass),
      .init  (init),
      .stable(stable[i]),
      .change(change[i])
    );
  end

  // 'stable' still holds the pre-change level, so a 0 there means a rising edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rise_en  = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    fall_en  = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    edge_set = change & ((~stable & {WIDTH{rise_en}}) | (stable & {WIDTH{fall_en}}));
    w1c      = '0;
    if (write && (address == ADDR_EDGE)) w1c = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0]  = stable;
      ADDR_MASK: rd_next[WIDTH-1:0]  = mask;
      ADDR_EDGE: rd_next[WIDTH-1:0]  = edges;
      ADDR_CTRL: rd_next[CTRL_W-1:0] = ctrl;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask     <= '0;
      edges    <= '0;
      ctrl     <= CTRL_RESET;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      // A capture on the same clk as a W1C of that bit wins.
      edges    <= (edges & ~w1c) | edge_set;
      irq      <= |(edges & mask);
      readdata <= rd_next;
      if (write && (address == ADDR_MASK)) mask <= writedata[WIDTH-1:0];
      if (write && (address == ADDR_CTRL)) ctrl <= writedata[CTRL_W-1:0];
    end
  end

endmodule
